// File: rtl/bus_responder.sv
// bus_responder: memory-bus target with word RAM, LED register, cycle counter and an optional 8N1 UART.
// Define BUS_RESPONDER_UART_EN to build the UART; without it TXD idles high and UART registers are inert.
module bus_responder #(
   parameter int WORDS    = 256,
   parameter int BAUD_DIV = 16
) (
   input  logic        clk,
   input  logic        RESET,
   input  logic [31:0] mem_addr,
   input  logic        mem_rstrb,
   output logic [31:0] mem_rdata,
   input  logic [31:0] mem_wdata,
   input  logic [3:0]  mem_wmask,
   output logic [4:0]  LEDS,
   output logic        TXD
);

   localparam int AW = $clog2(WORDS);

   // Bus handshake: a read is a one-cycle mem_rstrb pulse answered by mem_rdata on the
   // following cycle (held until the next strobe); a write is any cycle with nonzero mem_wmask.
   logic          is_io;
   logic [AW-1:0] word_idx;
   logic [2:0]    io_reg;
   logic          wr;

   assign is_io    = mem_addr[22];
   assign word_idx = mem_addr[AW+1:2];
   assign io_reg   = mem_addr[4:2];
   assign wr       = |mem_wmask;

   logic [31:0] ram [WORDS];
   logic [4:0]  leds_q;
   logic [31:0] cycle_cnt;
   logic        uart_busy;
   logic [31:0] io_rdata;
   logic [31:0] rd_next;

   logic unused_bits;
   assign unused_bits = ^{mem_addr, mem_wdata};

   // RAM has no reset; each byte lane is gated by its own mask bit.
   always_ff @(posedge clk) begin
      if (wr && !is_io) begin
         for (int i = 0; i < 4; i++) begin
            if (mem_wmask[i]) ram[word_idx][8*i +: 8] <= mem_wdata[8*i +: 8];
         end
      end
   end

   always_comb begin
      io_rdata = '0;
      case (io_reg)
         3'd0:    io_rdata = {27'd0, leds_q};
         3'd2:    io_rdata = {31'd0, uart_busy};
         3'd3:    io_rdata = cycle_cnt;
         default: io_rdata = '0;
      endcase
   end

   // Reads use pre-edge state, so a same-cycle write is not visible until the next read.
   assign rd_next = is_io ? io_rdata : ram[word_idx];

   always_ff @(posedge clk or posedge RESET) begin
      if (RESET) begin
         mem_rdata <= '0;
         leds_q    <= '0;
         cycle_cnt <= '0;
      end else begin
         cycle_cnt <= cycle_cnt + 32'd1;
         if (mem_rstrb) mem_rdata <= rd_next;
         if (wr && is_io && io_reg == 3'd0) leds_q <= mem_wdata[4:0];
      end
   end

   assign LEDS = leds_q;

`ifdef BUS_RESPONDER_UART_EN
   localparam int BW = $clog2(BAUD_DIV);
   localparam logic [BW-1:0] BAUD_LAST = BW'(BAUD_DIV - 1);

   typedef enum logic [1:0] {
      U_IDLE  = 2'd0,
      U_START = 2'd1,
      U_DATA  = 2'd2,
      U_STOP  = 2'd3
   } uart_state_t;

   uart_state_t   uart_state;
   logic [BW-1:0] baud_cnt;
   logic [2:0]    bit_cnt;
   logic [7:0]    tx_shift;
   logic          txd_q;
   logic          uart_write;
   logic          baud_end;

   assign uart_write = wr && is_io && (io_reg == 3'd1);
   assign baud_end   = (baud_cnt == BAUD_LAST);

   // The end of STOP may accept a new byte directly, so frames can run back to back.
   always_ff @(posedge clk or posedge RESET) begin
      if (RESET) begin
         uart_state <= U_IDLE;
         baud_cnt   <= '0;
         bit_cnt    <= '0;
         tx_shift   <= '0;
         txd_q      <= 1'b1;
      end else begin
         case (uart_state)
            U_IDLE: begin
               if (uart_write) begin
                  uart_state <= U_START;
                  baud_cnt   <= '0;
                  tx_shift   <= mem_wdata[7:0];
                  txd_q      <= 1'b0;
               end
            end
            U_START: begin
               if (baud_end) begin
                  baud_cnt   <= '0;
                  bit_cnt    <= '0;
                  uart_state <= U_DATA;
                  txd_q      <= tx_shift[0];
               end else begin
                  baud_cnt <= baud_cnt + 1'b1;
               end
            end
            U_DATA: begin
               if (baud_end) begin
                  baud_cnt <= '0;
                  if (bit_cnt == 3'd7) begin
                     uart_state <= U_STOP;
                     txd_q      <= 1'b1;
                  end else begin
                     bit_cnt  <= bit_cnt + 3'd1;
                     tx_shift <= {1'b0, tx_shift[7:1]};
                     txd_q    <= tx_shift[1];
                  end
               end else begin
                  baud_cnt <= baud_cnt + 1'b1;
               end
            end
            U_STOP: begin
               if (baud_end) begin
                  baud_cnt <= '0;
                  if (uart_write) begin
                     uart_state <= U_START;
                     tx_shift   <= mem_wdata[7:0];
                     txd_q      <= 1'b0;
                  end else begin
                     uart_state <= U_IDLE;
                  end
               end else begin
                  baud_cnt <= baud_cnt + 1'b1;
               end
            end
            default: uart_state <= U_IDLE;
         endcase
      end
   end

   assign uart_busy = (uart_state != U_IDLE);
   assign TXD       = txd_q;
`else
   assign uart_busy = 1'b0;
   assign TXD       = 1'b1;
`endif

endmodule
